// File: rtl/stream_demux_1_4.sv
// Registered 1:4 stream demultiplexer. Each channel has its own one-entry output
// register and handshake, so a stalled consumer never blocks traffic to the others.
module stream_demux_1_4 #(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [1:0]    in_sel,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [W-1:0]  out_data0,
   output logic [W-1:0]  out_data1,
   output logic [W-1:0]  out_data2,
   output logic [W-1:0]  out_data3,
   input  logic          cnt_clr,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1,
   output logic [CW-1:0] cnt2,
   output logic [CW-1:0] cnt3
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [3:0]    buf_valid;
   logic [W-1:0]  buf_data [4];
   logic [CW-1:0] cnt      [4];
   logic          in_xfer;

   // A channel can take a new word when empty or when its occupant drains this cycle.
   assign in_ready = ~buf_valid[in_sel] | out_ready[in_sel];
   assign in_xfer  = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= '0;
         for (int i = 0; i < 4; i++) begin
            buf_data[i] <= '0;
            cnt[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (in_xfer && (in_sel == 2'(i))) begin
               buf_valid[i] <= 1'b1;
               buf_data[i]  <= in_data;
            end else if (buf_valid[i] && out_ready[i]) begin
               buf_valid[i] <= 1'b0;
            end

            // Clear has priority; counters stick at their maximum instead of wrapping.
            if (cnt_clr) begin
               cnt[i] <= '0;
            end else if (buf_valid[i] && out_ready[i] && (cnt[i] != CNT_MAX)) begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign out_valid = buf_valid;
   assign out_data0 = buf_data[0];
   assign out_data1 = buf_data[1];
   assign out_data2 = buf_data[2];
   assign out_data3 = buf_data[3];
   assign cnt0      = cnt[0];
   assign cnt1      = cnt[1];
   assign cnt2      = cnt[2];
   assign cnt3      = cnt[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed bench for stream_demux_1_4: a per-channel queue of expected words and a
// counter model are updated as stimulus is driven and compared as the DUT delivers.
module tb_stream_demux_1_4;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [1:0] in_sel;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [3:0] out_data0, out_data1, out_data2, out_data3;
   logic       cnt_clr;
   logic [7:0] cnt0, cnt1, cnt2, cnt3;

   logic [3:0] dataw [4];
   logic [7:0] cntw  [4];

   logic [3:0] expq [4][$];
   int         mcnt [4];
   int         ncmp;
   int         nerr;

   stream_demux_1_4 #(.W(4), .CW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .cnt_clr   (cnt_clr),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
   );

   assign dataw[0] = out_data0;
   assign dataw[1] = out_data1;
   assign dataw[2] = out_data2;
   assign dataw[3] = out_data3;
   assign cntw[0]  = cnt0;
   assign cntw[1]  = cnt1;
   assign cntw[2]  = cnt2;
   assign cntw[3]  = cnt3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check the pre-edge view,
   // update the scoreboard, then check the counters after the rising edge.
   task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [3:0] d,
                                input logic [3:0] r, input logic clr);
      logic [3:0] drain;
      logic       exp_rdy;
      logic [3:0] word;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      cnt_clr   = clr;
      #1;
      exp_rdy = (expq[s].size() == 0) || r[s];
      checkOutput("in_ready", in_ready, exp_rdy);
      drain = '0;
      for (int c = 0; c < 4; c++) begin
         checkOutput($sformatf("out_valid%0d", c), out_valid[c], expq[c].size() != 0);
         if (expq[c].size() != 0) begin
            checkOutput($sformatf("out_data%0d", c), dataw[c], expq[c][0]);
            if (r[c]) begin
               drain[c] = 1'b1;
               word = expq[c].pop_front();
            end
         end
      end
      if (v && exp_rdy) expq[s].push_back(d);
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         if (clr) mcnt[c] = 0;
         else if (drain[c] && mcnt[c] < 255) mcnt[c]++;
         checkOutput($sformatf("cnt%0d", c), cntw[c], mcnt[c]);
      end
   endtask

   initial begin
      ncmp      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = 4'h0;
      out_ready = 4'hF;
      cnt_clr   = 1'b0;
      for (int c = 0; c < 4; c++) mcnt[c] = 0;

      #2;
      checkOutput("rst_out_valid", out_valid, 4'b0000);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_cnt3", cnt3, 8'd0);
      checkOutput("rst_data0", out_data0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] route all four channels");
      applyStimulus(1'b1, 2'd0, 4'hA, 4'hF, 1'b0);
      applyStimulus(1'b1, 2'd1, 4'hB, 4'hF, 1'b0);
      applyStimulus(1'b1, 2'd2, 4'hC, 4'hF, 1'b0);
      applyStimulus(1'b1, 2'd3, 4'hD, 4'hF, 1'b0);
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
      checkOutput("route_cnt1", cnt1, 8'd1);
      checkOutput("route_cnt3", cnt3, 8'd1);

      $display("[TB] stall isolation on channel 1");
      applyStimulus(1'b1, 2'd1, 4'h7, 4'b1101, 1'b0);
      applyStimulus(1'b1, 2'd1, 4'hA, 4'b1101, 1'b0);
      applyStimulus(1'b1, 2'd1, 4'hA, 4'b1101, 1'b0);
      checkOutput("stall_hold_data1", out_data1, 4'h7);
      applyStimulus(1'b1, 2'd2, 4'h3, 4'b1101, 1'b0);
      applyStimulus(1'b1, 2'd1, 4'hA, 4'b1111, 1'b0);
      checkOutput("stall_follow_data1", out_data1, 4'hA);
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
      checkOutput("stall_cnt1", cnt1, 8'd3);

      $display("[TB] back-to-back on channel 0");
      for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 2'd0, 4'(k), 4'hF, 1'b0);
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
      checkOutput("b2b_cnt0", cnt0, 8'd5);

      $display("[TB] counter saturation and clear on channel 3");
      for (int k = 0; k < 300; k++) applyStimulus(1'b1, 2'd3, 4'(k), 4'hF, 1'b0);
      applyStimulus(1'b1, 2'd3, 4'h5, 4'hF, 1'b0);
      checkOutput("sat_cnt3", cnt3, 8'd255);
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF, 1'b1);
      checkOutput("clr_cnt3", cnt3, 8'd0);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 2'd0, 4'h5, 4'b1010, 1'b0);
      applyStimulus(1'b1, 2'd2, 4'h6, 4'b1010, 1'b0);
      checkOutput("pre_rst_valid", out_valid, 4'b0101);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", out_valid, 4'b0000);
      checkOutput("midrst_data0", out_data0, 4'h0);
      checkOutput("midrst_data2", out_data2, 4'h0);
      checkOutput("midrst_cnt0", cnt0, 8'd0);
      checkOutput("midrst_cnt1", cnt1, 8'd0);
      checkOutput("midrst_in_ready", in_ready, 1'b1);
      for (int c = 0; c < 4; c++) begin
         expq[c].delete();
         mcnt[c] = 0;
      end
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'd2, 4'hF, 4'hF, 1'b0);
      checkOutput("post_rst_data2", out_data2, 4'hF);
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
      checkOutput("post_rst_cnt2", cnt2, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Registered 1:4 stream demultiplexer; the inverse of the team's 4:1 case-based mux.
- Accepts one valid/ready input stream and steers each word to the output channel selected by in_sel.
- Each channel has a one-entry output register with its own valid/ready handshake, so a stalled channel never blocks traffic to the other channels.
- Per-channel saturating transfer counters support debug and verification.

Parameters:
- W, 4, data word width in bits.
- CW, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word on in_data/in_sel this cycle.
- in_data  input  W  input word.
- in_sel  input  2  destination channel 0..3.
- out_valid  output  4  bit i: channel i holds a word.
- out_ready  input  4  bit i: channel i consumer accepts.
- out_data0, out_data1, out_data2, out_data3  output  W each  channel data.
- cnt_clr  input  1  synchronous clear of all counters.
- cnt0, cnt1, cnt2, cnt3  output  CW each  completed output transfers per channel.

Behaviour:
- Reset (rst_n=0, takes effect immediately and asynchronously):
  - out_valid=4'b0000, all out_data*=0, all cnt*=0.
  - in_ready follows its combinational equation, so it reads 1 during reset.
  - Any word held when reset asserts is discarded.
- State per channel i: buf_valid[i] and buf_data[i].
  - out_valid[i]=buf_valid[i]; out_data_i=buf_data[i].
  - Both come directly from registers, with no combinational path from the inputs.
- in_ready = ~buf_valid[in_sel] | out_ready[in_sel].
  - This is combinational from in_sel and out_ready. It allows a word to be accepted in the same cycle the occupant of the selected channel drains.
  - in_ready does not depend on in_valid.
- Input transfer: in_valid & in_ready at a clock edge.
  - buf_data[in_sel] <= in_data and buf_valid[in_sel] <= 1.
- Output transfer on channel i: buf_valid[i] & out_ready[i].
  - buf_valid[i] <= 0, unless the same edge also carries an input transfer into channel i.
  - In that simultaneous case buf_valid stays 1 and the new word is loaded (back-to-back, one word per cycle per channel).
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle after acceptance.
- Channel independence:
  - Channel i with out_valid=1 and out_ready=0 holds out_data_i stable indefinitely.
  - Input words addressed to other channels continue to flow.
- No reordering within a channel. The block has no ordering relationship across channels.
- Data registers update only on an input transfer. On drain they keep their last value; the value is meaningless while out_valid=0.
- in_sel and in_data are ignored when in_valid=0.
- Counters:
  - cnt_i increments by 1 on each output transfer on channel i.
  - cnt_i saturates at 2^CW-1 and does not wrap.
  - cnt_clr=1 sets all counters to 0 at the edge; clear wins over a simultaneous increment.
- Handshake rules:
  - The upstream source must hold in_data/in_sel stable while in_valid=1 and in_ready=0.
  - The block keeps out_valid[i]=1 until a transfer completes (it never retracts a valid).

Test Plan:
- Route all four: send a,b,c,d with sel 0,1,2,3, all out_ready=1 → each channel shows its word one cycle after acceptance (out_data0=a, out_data1=b, out_data2=c, out_data3=d), out_valid pulses for one cycle, cnt0..cnt3=1.
- Stall isolation: out_ready=4'b1101, send 7 to sel1 then 10 to sel1 then 3 to sel2 → ch1 holds 7 with in_ready=0 while in_sel=1; the word 3 is accepted for ch2 and delivered; after out_ready[1]=1, 10 follows 7; cnt1=2.
- Back-to-back same channel: sel0, out_ready[0]=1, stream 1,2,3,4 on consecutive cycles → in_ready stays 1, ch0 delivers 1,2,3,4 on consecutive cycles, cnt0=4.
- Counter saturation and clear: CW=8, 300 transfers on ch3 → cnt3=255; assert cnt_clr in the same cycle as a transfer → cnt3=0 next cycle.
- Reset mid-operation: ch0 and ch2 full and stalled, pulse rst_n low between edges → out_valid=0, all counters 0, and out_data*=0 immediately; after release, sending 'hf to sel2 delivers normally.
